// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - integer register file with per-register busy scoreboard
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read forwarding on all read ports)
module regfile_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                flush,
  output logic                any_busy
);

  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] busy;

  // Register storage: write-back port, register 0 is never written so it stays zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        rf[r] <= '0;
      end
    end else if (we && (wa != '0)) begin
      rf[wa] <= wd;
    end
  end

  // Scoreboard: flush beats issue, issue beats retire, so a new producer supersedes the retiring one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        if (flush) begin
          busy[r] <= 1'b0;
        end else if (iss_valid && (iss_rd == AW'(r))) begin
          busy[r] <= 1'b1;
        end else if (we && (wa == AW'(r))) begin
          busy[r] <= 1'b0;
        end
      end
    end
  end

  // Combinational read ports; register 0 reads as zero and never busy
  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (ra[i*AW +: AW] != '0) begin
        rd[i*XLEN +: XLEN] = rf[ra[i*AW +: AW]];
        rbusy[i]           = busy[ra[i*AW +: AW]];
`ifdef RF_BYPASS_EN
        // Forward the in-flight write-back; only a same-cycle re-issue keeps the register busy.
        // Gated by reset so the outputs read as cleared while reset is held.
        if (!reset && we && (wa == ra[i*AW +: AW])) begin
          rd[i*XLEN +: XLEN] = wd;
          rbusy[i]           = iss_valid && (iss_rd == ra[i*AW +: AW]);
        end
`endif
      end
    end
  end

  // Drain indicator reflects the registered scoreboard only
  assign any_busy = |busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - scoreboard-style directed bench for regfile_scoreboard
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk = 1'b0;
  logic                clk_en = 1'b0;
  logic                reset = 1'b0;
  logic [NRD*AW-1:0]   ra = '0;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rbusy;
  logic                iss_valid = 1'b0;
  logic [AW-1:0]       iss_rd = '0;
  logic                we = 1'b0;
  logic [AW-1:0]       wa = '0;
  logic [XLEN-1:0]     wd = '0;
  logic                flush = 1'b0;
  logic                any_busy;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(32), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rd(rd), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .we(we), .wa(wa), .wd(wd),
    .flush(flush), .any_busy(any_busy)
  );

  initial forever #5 clk = clk_en ? ~clk : clk;

  typedef struct {
    string       name;
    int          port;
    logic [31:0] exp_rd;
    logic        exp_busy;
    logic        exp_any;
  } exp_t;

  exp_t q[$];
  event chk_ev;
  int   n_vec  = 0;
  int   n_fail = 0;

  // Monitor: pops each queued expectation and compares it against the live outputs
  initial begin
    forever begin
      @(chk_ev);
      while (q.size() != 0) begin
        exp_t e;
        logic [31:0] a_rd;
        e    = q.pop_front();
        a_rd = rd[e.port*XLEN +: XLEN];
        n_vec++;
        if (a_rd !== e.exp_rd || rbusy[e.port] !== e.exp_busy || any_busy !== e.exp_any) begin
          n_fail++;
          $display("FAIL %s port%0d: got rd=%h rbusy=%b any_busy=%b, want rd=%h rbusy=%b any_busy=%b",
                   e.name, e.port, a_rd, rbusy[e.port], any_busy, e.exp_rd, e.exp_busy, e.exp_any);
        end
      end
    end
  end

  task automatic chk(input string nm, input int p, input logic [31:0] erd,
                     input logic ebusy, input logic eany);
    exp_t e;
    #1;
    e.name = nm; e.port = p; e.exp_rd = erd; e.exp_busy = ebusy; e.exp_any = eany;
    q.push_back(e);
    -> chk_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  initial begin
    // 1. reset with clock stopped
    set_ra(5'd5, 5'd5);
    #1 reset = 1'b1;
    chk("reset_p0", 0, 32'h0, 1'b0, 1'b0);
    chk("reset_p1", 1, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("post_reset_r5", 0, 32'h0, 1'b0, 1'b0);
    clk_en = 1'b1;
    tick();

    // 2. basic write/read, write to r0 ignored
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
`ifdef RF_BYPASS_EN
    chk("wr5_pre_edge", 0, 32'hDEADBEEF, 1'b0, 1'b0);
`else
    chk("wr5_pre_edge", 0, 32'h0, 1'b0, 1'b0);
`endif
    tick();
    we = 1'b0;
    chk("wr5_read", 0, 32'hDEADBEEF, 1'b0, 1'b0);
    we = 1'b1; wa = 5'd0; wd = 32'h1234; set_ra(5'd0, 5'd5);
    tick();
    we = 1'b0;
    chk("r0_reads_zero", 0, 32'h0, 1'b0, 1'b0);
    chk("r5_port1", 1, 32'hDEADBEEF, 1'b0, 1'b0);

    // 3. scoreboard set and retire
    iss_valid = 1'b1; iss_rd = 5'd7; set_ra(5'd7, 5'd0);
    tick();
    iss_valid = 1'b0;
    chk("iss7_busy", 0, 32'h0, 1'b1, 1'b1);
    chk("iss0_port1", 1, 32'h0, 1'b0, 1'b1);
    we = 1'b1; wa = 5'd7; wd = 32'h55;
`ifndef RF_BYPASS_EN
    chk("wb7_pre_edge", 0, 32'h0, 1'b1, 1'b1);
`endif
    tick();
    we = 1'b0;
    chk("wb7_retired", 0, 32'h55, 1'b0, 1'b0);

    // 4. set wins over clear; flush wins over both
    iss_valid = 1'b1; iss_rd = 5'd3; set_ra(5'd3, 5'd0);
    tick();
    chk("iss3_busy", 0, 32'h0, 1'b1, 1'b1);
    we = 1'b1; wa = 5'd3; wd = 32'd9;
    tick();
    chk("set_beats_clear", 0, 32'd9, 1'b1, 1'b1);
    wd = 32'd10; flush = 1'b1;
    tick();
    iss_valid = 1'b0; we = 1'b0; flush = 1'b0;
    chk("flush_drops_issue", 0, 32'd10, 1'b0, 1'b0);

    // WAW reissue keeps busy until the next write-back
    iss_valid = 1'b1; iss_rd = 5'd8; set_ra(5'd8, 5'd3);
    tick();
    tick();
    iss_valid = 1'b0;
    chk("waw_busy", 0, 32'h0, 1'b1, 1'b1);
    we = 1'b1; wa = 5'd8; wd = 32'hCAFE;
    tick();
    we = 1'b0;
    chk("waw_retired", 0, 32'hCAFE, 1'b0, 1'b0);

    // 5. read of an in-flight write
    we = 1'b1; wa = 5'd4; wd = 32'hA5A5; set_ra(5'd4, 5'd4);
`ifdef RF_BYPASS_EN
    chk("byp_p0", 0, 32'hA5A5, 1'b0, 1'b0);
    chk("byp_p1", 1, 32'hA5A5, 1'b0, 1'b0);
`else
    chk("old_p0", 0, 32'h0, 1'b0, 1'b0);
    chk("old_p1", 1, 32'h0, 1'b0, 1'b0);
`endif
    tick();
    we = 1'b0;
    chk("after_p0", 0, 32'hA5A5, 1'b0, 1'b0);
    chk("after_p1", 1, 32'hA5A5, 1'b0, 1'b0);

    // 6. reset mid-operation
    iss_valid = 1'b1; iss_rd = 5'd2;
    tick();
    iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    we = 1'b1; wa = 5'd9; wd = 32'h77; set_ra(5'd9, 5'd2);
    chk("pending_r2", 1, 32'h0, 1'b1, 1'b1);
    #1 reset = 1'b1;
    chk("midreset_p0", 0, 32'h0, 1'b0, 1'b0);
    chk("midreset_p1", 1, 32'h0, 1'b0, 1'b0);
    tick();
    we = 1'b0;
    reset = 1'b0;
    tick();
    chk("r9_after_reset", 0, 32'h0, 1'b0, 1'b0);
    chk("r2_after_reset", 1, 32'h0, 1'b0, 1'b0);
    set_ra(5'd5, 5'd4);
    chk("r5_cleared", 0, 32'h0, 1'b0, 1'b0);
    chk("r4_cleared", 1, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 100 && q.size() != 0; i++) #1;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
